fft_bfly_pipe: RTL and testbench
================================

FFT_BFLY_PIPE -- requirements
Module: fft_bfly_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; reset is asserted while rst_n_i is low.
REQ-002 The block SHALL have these parameters:
- DATA_WID, default 16: signed width of each re/im data component, in and out.
- TW_WID, default 16: signed twiddle width, format Q1.(TW_WID-1).

REQ-003 The block SHALL have these ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  async active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  block accepts input this cycle.
- a_re_i, a_im_i  in  DATA_WID  operand A.
- b_re_i, b_im_i  in  DATA_WID  operand B.
- wn_re_i, wn_im_i  in  TW_WID  twiddle W.
- scale_i  in  1  1 = divide results by 2 with rounding.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts output.
- x1_re_o, x1_im_o  out  DATA_WID  X1 = A + W*B.
- x2_re_o, x2_im_o  out  DATA_WID  X2 = A - W*B.
- ovf_o  out  1  sticky overflow flag.
- ovf_clr_i  in  1  clears ovf_o.

Function
REQ-004 The block SHALL compute the radix-2 DIT butterfly X1 = A + W*B and X2 = A - W*B, with all values in signed two's complement.
REQ-005 The pipeline SHALL have 3 register stages, so an accepted beat appears on out_valid_o exactly 3 cycles later when there is no stall:
- S1 registers the operands and scale_i.
- S2 registers the four products B*W.
- S3 registers the rounded, scaled and limited results.

REQ-006 W*B SHALL be computed as follows:
- re = b_re*wn_re - b_im*wn_im, and im = b_re*wn_im + b_im*wn_re.
- Each is computed at full width DATA_WID+TW_WID+1.
- Each is then rounded half-up: add 2^(TW_WID-2), then arithmetic shift right by TW_WID-1.

REQ-007 The sums A +/- W*B SHALL be formed at DATA_WID+2 bits. When the beat's scale bit is 1, each sum SHALL have 1 added and then be arithmetic-shifted right by 1.
REQ-008 A result component outside [-2^(DATA_WID-1), 2^(DATA_WID-1)-1] after REQ-007 SHALL be treated as an overflow event for that beat.
REQ-009 Handshake SHALL use a global pipeline enable, en = !out_valid_o || out_ready_i:
- in_ready_o = en.
- A beat is accepted when in_valid_i && in_ready_o.
- All stages advance only when en is high.

REQ-010 While out_valid_o=1 and out_ready_i=0, the outputs SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-011 Bubbles SHALL propagate as invalid stages, and valid bits SHALL advance with en exactly like the data.
REQ-012 ovf_o SHALL set on the cycle after a beat with an overflow event is loaded into S3, and SHALL remain set until ovf_clr_i is sampled high.
REQ-013 If ovf_clr_i and a new overflow event occur in the same cycle, the set SHALL win.
REQ-014 scale_i SHALL be captured per beat, so that changing it between beats affects only subsequently accepted beats.

Reset
REQ-015 While rst_n_i is low, the block SHALL force the following, asynchronously:
- all stage valid bits = 0.
- out_valid_o = 0.
- all x*_o = 0.
- ovf_o = 0.

REQ-016 Reset asserted mid-operation SHALL discard all in-flight beats, with no output of them after release.
REQ-017 in_ready_o SHALL be 1 from the first clock edge after reset release.

Configuration
REQ-018 With macro FFT_BFLY_SAT_EN defined, an out-of-range result SHALL saturate to the nearest DATA_WID limit.
REQ-019 Without FFT_BFLY_SAT_EN, an out-of-range result SHALL wrap, keeping its low DATA_WID bits.
REQ-020 In both builds of REQ-018/REQ-019, ovf_o SHALL be flagged identically.

Verification
REQ-021 The bench SHALL cover these directed scenarios (DATA_WID=TW_WID=16 for all):
- Identity: A=(1000,0), B=(1000,0), W=(0x7FFF,0), scale=0 -> X1=(2000,0), X2=(0,0); out_valid 3 cycles after accept. With scale=1 -> X1=(1000,0), X2=(0,0).
- Twiddle -j: A=(0,0), B=(1000,0), W=(0,-32768), scale=0 -> X1=(0,-1000), X2=(0,1000).
- Overflow: A=(32767,0), B=(32767,0), W=(0x7FFF,0), scale=0 -> with FFT_BFLY_SAT_EN, X1.re=32767; without it, X1.re=-3; X2.re=1 and ovf_o=1 in both builds. With scale=1 -> X1.re=32767, X2.re=1 (no ovf_o set). Pulsing ovf_clr_i -> ovf_o=0.
- Back-pressure: stream 8 beats, hold out_ready_i=0 for 5 cycles mid-stream -> in_ready_o=0 while stalled, outputs stable, all 8 results in order with no loss or duplication.
- Reset mid-stream: assert rst_n_i low with 3 beats in flight -> out_valid_o=0 and ovf_o=0 immediately; no stale beat after release; a new beat is accepted on the first cycle.

Source files
------------

// File: rtl/fft_bfly_pipe.sv
// Three-stage radix-2 DIT butterfly: X1 = A + W*B, X2 = A - W*B.
// Define FFT_BFLY_SAT_EN to saturate out-of-range results instead of wrapping.
module fft_bfly_pipe #(
    parameter int DATA_WID = 16,
    parameter int TW_WID   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic signed [DATA_WID-1:0] a_re_i,
    input  logic signed [DATA_WID-1:0] a_im_i,
    input  logic signed [DATA_WID-1:0] b_re_i,
    input  logic signed [DATA_WID-1:0] b_im_i,
    input  logic signed [TW_WID-1:0]   wn_re_i,
    input  logic signed [TW_WID-1:0]   wn_im_i,
    input  logic                       scale_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [DATA_WID-1:0] x1_re_o,
    output logic signed [DATA_WID-1:0] x1_im_o,
    output logic signed [DATA_WID-1:0] x2_re_o,
    output logic signed [DATA_WID-1:0] x2_im_o,
    output logic                       ovf_o,
    input  logic                       ovf_clr_i
);

    localparam int PRW = DATA_WID + TW_WID;
    localparam int PW  = PRW + 1;
    localparam int SW  = DATA_WID + 2;

    localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (TW_WID-2);
    localparam logic signed [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};

    logic r1_v, r2_v, r3_v;
    logic r1_sc, r2_sc;
    logic signed [DATA_WID-1:0] r1_a_re, r1_a_im, r1_b_re, r1_b_im;
    logic signed [TW_WID-1:0]   r1_w_re, r1_w_im;
    logic signed [DATA_WID-1:0] r2_a_re, r2_a_im;
    logic signed [PRW-1:0]      r2_p_rr, r2_p_ii, r2_p_ri, r2_p_ir;
    logic signed [DATA_WID-1:0] r3_x1_re, r3_x1_im, r3_x2_re, r3_x2_im;
    logic                       r_ovf;

    logic                       w_en;
    logic signed [PW-1:0]       w_full_re, w_full_im;
    logic signed [SW-1:0]       w_wb_re, w_wb_im;
    logic signed [SW-1:0]       w_s1_re, w_s1_im, w_s2_re, w_s2_im;
    logic signed [SW-1:0]       w_v1_re, w_v1_im, w_v2_re, w_v2_im;
    logic                       w_ovf;

    function automatic logic signed [SW-1:0] f_scale(
        input logic signed [SW-1:0] s, input logic sc);
        logic signed [SW-1:0] t;
        t = s + ONE;
        return sc ? (t >>> 1) : s;
    endfunction

    // Out of range when the bits above the DATA_WID sign bit disagree with it.
    function automatic logic f_ovf(input logic signed [SW-1:0] v);
        return !((&v[SW-1:DATA_WID-1]) || !(|v[SW-1:DATA_WID-1]));
    endfunction

    function automatic logic signed [DATA_WID-1:0] f_lim(
        input logic signed [SW-1:0] v);
`ifdef FFT_BFLY_SAT_EN
        if (f_ovf(v))
            return v[SW-1] ? {1'b1, {(DATA_WID-1){1'b0}}}
                           : {1'b0, {(DATA_WID-1){1'b1}}};
        return v[DATA_WID-1:0];
`else
        return v[DATA_WID-1:0];
`endif
    endfunction

    assign w_en        = !r3_v || out_ready_i;
    assign in_ready_o  = w_en;
    assign out_valid_o = r3_v;
    assign x1_re_o     = r3_x1_re;
    assign x1_im_o     = r3_x1_im;
    assign x2_re_o     = r3_x2_re;
    assign x2_im_o     = r3_x2_im;
    assign ovf_o       = r_ovf;

    assign w_full_re = PW'(r2_p_rr) - PW'(r2_p_ii);
    assign w_full_im = PW'(r2_p_ri) + PW'(r2_p_ir);
    assign w_wb_re   = SW'((w_full_re + RND) >>> (TW_WID-1));
    assign w_wb_im   = SW'((w_full_im + RND) >>> (TW_WID-1));
    assign w_s1_re   = SW'(r2_a_re) + w_wb_re;
    assign w_s1_im   = SW'(r2_a_im) + w_wb_im;
    assign w_s2_re   = SW'(r2_a_re) - w_wb_re;
    assign w_s2_im   = SW'(r2_a_im) - w_wb_im;
    assign w_v1_re   = f_scale(w_s1_re, r2_sc);
    assign w_v1_im   = f_scale(w_s1_im, r2_sc);
    assign w_v2_re   = f_scale(w_s2_re, r2_sc);
    assign w_v2_im   = f_scale(w_s2_im, r2_sc);
    assign w_ovf     = f_ovf(w_v1_re) | f_ovf(w_v1_im)
                     | f_ovf(w_v2_re) | f_ovf(w_v2_im);

    // S1: capture operands, twiddle and per-beat scale bit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r1_v    <= 1'b0;
            r1_sc   <= 1'b0;
            r1_a_re <= '0;
            r1_a_im <= '0;
            r1_b_re <= '0;
            r1_b_im <= '0;
            r1_w_re <= '0;
            r1_w_im <= '0;
        end else if (w_en) begin
            r1_v    <= in_valid_i;
            r1_sc   <= scale_i;
            r1_a_re <= a_re_i;
            r1_a_im <= a_im_i;
            r1_b_re <= b_re_i;
            r1_b_im <= b_im_i;
            r1_w_re <= wn_re_i;
            r1_w_im <= wn_im_i;
        end
    end

    // S2: the four partial products of W*B, A and scale carried along
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r2_v    <= 1'b0;
            r2_sc   <= 1'b0;
            r2_a_re <= '0;
            r2_a_im <= '0;
            r2_p_rr <= '0;
            r2_p_ii <= '0;
            r2_p_ri <= '0;
            r2_p_ir <= '0;
        end else if (w_en) begin
            r2_v    <= r1_v;
            r2_sc   <= r1_sc;
            r2_a_re <= r1_a_re;
            r2_a_im <= r1_a_im;
            r2_p_rr <= PRW'(r1_b_re) * PRW'(r1_w_re);
            r2_p_ii <= PRW'(r1_b_im) * PRW'(r1_w_im);
            r2_p_ri <= PRW'(r1_b_re) * PRW'(r1_w_im);
            r2_p_ir <= PRW'(r1_b_im) * PRW'(r1_w_re);
        end
    end

    // S3: rounded, scaled, range-limited results
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r3_v     <= 1'b0;
            r3_x1_re <= '0;
            r3_x1_im <= '0;
            r3_x2_re <= '0;
            r3_x2_im <= '0;
        end else if (w_en) begin
            r3_v     <= r2_v;
            r3_x1_re <= f_lim(w_v1_re);
            r3_x1_im <= f_lim(w_v1_im);
            r3_x2_re <= f_lim(w_v2_re);
            r3_x2_im <= f_lim(w_v2_im);
        end
    end

    // Sticky overflow; a new event beats a simultaneous clear
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_ovf <= 1'b0;
        else if (w_en && r2_v && w_ovf)
            r_ovf <= 1'b1;
        else if (ovf_clr_i)
            r_ovf <= 1'b0;
    end

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed bench for fft_bfly_pipe with an arithmetic reference model.
// Build with FFT_BFLY_SAT_EN defined to check the saturating variant.
module tb_fft_bfly_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready;
    logic signed [15:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic signed [15:0] w_re = '0, w_im = '0;
    logic scale = 1'b0;
    logic out_valid, out_ready = 1'b1;
    logic signed [15:0] x1_re, x1_im, x2_re, x2_im;
    logic ovf, ovf_clr = 1'b0;

    always #5 clk = ~clk;

    fft_bfly_pipe #(.DATA_WID(16), .TW_WID(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_re_i(a_re), .a_im_i(a_im), .b_re_i(b_re), .b_im_i(b_im),
        .wn_re_i(w_re), .wn_im_i(w_im), .scale_i(scale),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .x1_re_o(x1_re), .x1_im_o(x1_im), .x2_re_o(x2_re), .x2_im_o(x2_im),
        .ovf_o(ovf), .ovf_clr_i(ovf_clr)
    );

    typedef struct {int ar, ai, br, bi, wr, wi; bit sc;} beat_t;
    typedef struct {int x1r, x1i, x2r, x2i; bit ovf;} res_t;

    res_t  q[$];
    beat_t cur;
    int    n_cmp = 0, n_err = 0, n_out = 0;
    bit    held = 1'b0;
    int    h[4];

`ifdef FFT_BFLY_SAT_EN
    localparam int OVF_X1R = 32767;
`else
    localparam int OVF_X1R = -3;
`endif

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lim(input longint v);
`ifdef FFT_BFLY_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
`endif
    endfunction

    function automatic res_t model(input beat_t b);
        res_t r;
        longint pr, pi, s[4];
        pr = (longint'(b.br) * b.wr - longint'(b.bi) * b.wi + 16384) >>> 15;
        pi = (longint'(b.br) * b.wi + longint'(b.bi) * b.wr + 16384) >>> 15;
        s[0] = b.ar + pr;
        s[1] = b.ai + pi;
        s[2] = b.ar - pr;
        s[3] = b.ai - pi;
        r.ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (b.sc) s[i] = (s[i] + 1) >>> 1;
            if (s[i] > 32767 || s[i] < -32768) r.ovf = 1'b1;
        end
        r.x1r = lim(s[0]);
        r.x1i = lim(s[1]);
        r.x2r = lim(s[2]);
        r.x2i = lim(s[3]);
        return r;
    endfunction

    // Compare process: stall stability, in-order results, accept tracking
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (out_valid) begin
                if (held) begin
                    chk("hold_x1re", x1_re, h[0]);
                    chk("hold_x1im", x1_im, h[1]);
                    chk("hold_x2re", x2_re, h[2]);
                    chk("hold_x2im", x2_im, h[3]);
                end
                if (out_ready) begin
                    chk("stray_output", q.size() > 0, 1);
                    if (q.size() > 0) begin
                        res_t e;
                        e = q.pop_front();
                        chk("mdl_x1re", x1_re, e.x1r);
                        chk("mdl_x1im", x1_im, e.x1i);
                        chk("mdl_x2re", x2_re, e.x2r);
                        chk("mdl_x2im", x2_im, e.x2i);
                        if (e.ovf) chk("mdl_ovf", ovf, 1);
                    end
                    n_out++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    h[0] = x1_re; h[1] = x1_im;
                    h[2] = x2_re; h[3] = x2_im;
                end
            end
            if (in_valid && in_ready) q.push_back(model(cur));
        end
    end

    task automatic drive_beat(input beat_t b, output int w);
        cur = b;
        a_re = 16'(b.ar); a_im = 16'(b.ai);
        b_re = 16'(b.br); b_im = 16'(b.bi);
        w_re = 16'(b.wr); w_im = 16'(b.wi);
        scale = b.sc;
        in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", w, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run1(input string nm, input beat_t b,
                        input int e0, input int e1, input int e2, input int e3,
                        input int eovf);
        int w, lat;
        drive_beat(b, w);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_x1re"}, x1_re, e0);
        chk({nm, "_x1im"}, x1_im, e1);
        chk({nm, "_x2re"}, x2_re, e2);
        chk({nm, "_x2im"}, x2_im, e3);
        if (eovf >= 0) chk({nm, "_ovf"}, ovf, eovf);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        beat_t id0, id1, mj, ov0, ov1, bp;
        res_t  m;
        int    w, n0, cyc;

        id0 = '{1000, 0, 1000, 0, 32767, 0, 1'b0};
        id1 = '{1000, 0, 1000, 0, 32767, 0, 1'b1};
        mj  = '{0, 0, 1000, 0, 0, -32768, 1'b0};
        ov0 = '{32767, 0, 32767, 0, 32767, 0, 1'b0};
        ov1 = '{32767, 0, 32767, 0, 32767, 0, 1'b1};

        m = model(id0);
        chk("pin_model_id_x1re", m.x1r, 2000);
        m = model(mj);
        chk("pin_model_mj_x1im", m.x1i, -1000);
        m = model(ov0);
        chk("pin_model_ov_x1re", m.x1r, OVF_X1R);

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_x1re", x1_re, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", in_ready, 1);

        run1("ident_s0", id0, 2000, 0, 0, 0, 0);
        run1("ident_s1", id1, 1000, 0, 0, 0, 0);
        run1("minus_j",  mj, 0, -1000, 0, 1000, 0);
        run1("ovf_s1",   ov1, 32767, 0, 1, 0, 0);
        run1("ovf_s0",   ov0, OVF_X1R, 0, 1, 0, 1);

        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);

        drive_beat(ov0, w);
        drive_beat(id0, w);
        drive_beat(mj, w);
        chk("inflight_valid", out_valid, 1);
        chk("inflight_ovf", ovf, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_x1re", x1_re, 0);
        chk("midrst_x2re", x2_re, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst_ready", in_ready, 1);
        n0 = n_out;
        run1("post_rst", id1, 1000, 0, 0, 0, 0);
        chk("post_rst_count", n_out - n0, 1);

        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bp.ar = 1000 * i - 3000;
                    bp.ai = 500 - 200 * i;
                    bp.br = 700 * i - 2000;
                    bp.bi = 300 * i;
                    bp.wr = (i % 2 == 1) ? 23170 : -16384;
                    bp.wi = (i % 2 == 1) ? -23170 : 12000;
                    bp.sc = (i % 3 == 0);
                    drive_beat(bp, w);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_stall_valid", out_valid, 1);
                    chk("bp_stall_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        cyc = 0;
        while (n_out - n0 < 8 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("bp_count", n_out - n0, 8);
        chk("bp_queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
